// File: rtl/sig_phase_sequencer.sv
// Run controller for the signature-test datapath: sequences equal-length test phases, drives the
// reset pattern, counter gating and scrambler seed, and captures one signature per phase.
module sig_phase_sequencer #(
  parameter int unsigned PHASE_LEN         = 320,
  parameter int unsigned NUM_PHASES        = 3,
  parameter int unsigned CAPTURE_CYCLE     = 310,
  parameter int unsigned SEED_SWITCH_PHASE = 2,
  parameter logic [7:0]  SEED_A            = 8'hAA,
  parameter logic [7:0]  SEED_B            = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        counter_full,
  input  logic [15:0] acc_value,
  output logic        dut_reset,
  output logic        cnt_en,
  output logic [7:0]  seed,
  output logic [3:0]  phase,
  output logic        busy,
  output logic        done,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic [15:0] sig_data,
  output logic [3:0]  sig_phase,
  output logic [7:0]  sig_seed,
  output logic        overrun
);

  localparam logic [15:0] LastCyc   = 16'(PHASE_LEN - 1);
  localparam logic [15:0] CapCyc    = 16'(CAPTURE_CYCLE);
  localparam logic [3:0]  LastPhase = 4'(NUM_PHASES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [3:0]  phase_q, phase_d;
  logic        sig_valid_q, sig_valid_d;
  logic [15:0] sig_data_q, sig_data_d;
  logic [3:0]  sig_phase_q, sig_phase_d;
  logic [7:0]  sig_seed_q, sig_seed_d;
  logic        overrun_q, overrun_d;

  logic in_pulse;
  logic capture;
  logic accept;

  // Multi-pulse reset pattern applied at the start of every phase.
  always_comb begin
    in_pulse = 1'b0;
    case (cyc_q)
      16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd8, 16'd17: in_pulse = 1'b1;
      default: in_pulse = 1'b0;
    endcase
  end

  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    dut_reset = !busy || in_pulse;
    cnt_en    = busy && !in_pulse && !counter_full;
    seed      = ({28'd0, phase_q} < SEED_SWITCH_PHASE) ? SEED_A : SEED_B;
    phase     = phase_q;
    sig_valid = sig_valid_q;
    sig_data  = sig_data_q;
    sig_phase = sig_phase_q;
    sig_seed  = sig_seed_q;
    overrun   = overrun_q;
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    phase_d = phase_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cyc_d   = 16'd0;
          phase_d = 4'd0;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          cyc_d   = 16'd0;
          phase_d = 4'd0;
        end else if (cyc_q == LastCyc) begin
          cyc_d = 16'd0;
          if (phase_q == LastPhase) begin
            state_d = StDone;
            phase_d = 4'd0;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 16'd0;
        phase_d = 4'd0;
      end
    endcase
  end

  // Single-entry capture buffer; a capture landing on an accept edge refills it in place.
  always_comb begin
    capture     = busy && (cyc_q == CapCyc);
    accept      = sig_valid_q && sig_ready;
    sig_valid_d = sig_valid_q;
    sig_data_d  = sig_data_q;
    sig_phase_d = sig_phase_q;
    sig_seed_d  = sig_seed_q;
    overrun_d   = overrun_q;
    if (capture && (!sig_valid_q || accept)) begin
      sig_valid_d = 1'b1;
      sig_data_d  = acc_value;
      sig_phase_d = phase_q;
      sig_seed_d  = seed;
    end else if (capture) begin
      overrun_d = 1'b1;
    end else if (accept) begin
      sig_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cyc_q       <= 16'd0;
      phase_q     <= 4'd0;
      sig_valid_q <= 1'b0;
      sig_data_q  <= 16'd0;
      sig_phase_q <= 4'd0;
      sig_seed_q  <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      phase_q     <= phase_d;
      sig_valid_q <= sig_valid_d;
      sig_data_q  <= sig_data_d;
      sig_phase_q <= sig_phase_d;
      sig_seed_q  <= sig_seed_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: doc/sig_phase_sequencer.md
# sig_phase_sequencer

Run controller for the processor signature-test datapath: the stimulus counter, the 16-bit rotate/accumulate signature register and the scrambler seed. It sequences a fixed number of equal-length test phases. In each phase it drives a multi-pulse reset pattern into the processor under test, gates the counter and accumulator, and selects the scrambler seed. At a fixed cycle of each phase it captures the accumulator value and delivers it through a valid/ready port to the answer-code logger.

## Interface
Parameters:
- PHASE_LEN, 320, cycles per phase (2..65535).
- NUM_PHASES, 3, number of phases per run (1..15).
- CAPTURE_CYCLE, 310, in-phase cycle index at which acc_value is sampled (< PHASE_LEN).
- SEED_SWITCH_PHASE, 2, first phase index that uses SEED_B.
- SEED_A, 8'hAA, seed for phases below SEED_SWITCH_PHASE.
- SEED_B, 8'hFF, seed for the remaining phases.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a run; sampled only in IDLE.
- abort  in  1  synchronous run cancel.
- counter_full  in  1  stimulus counter equals 8'hFF.
- acc_value  in  16  accumulator output.
- dut_reset  out  1  reset to the processor, the counter and the accumulator.
- cnt_en  out  1  counter and accumulator update enable.
- seed  out  8  scrambler seed.
- phase  out  4  current phase index.
- busy  out  1  FSM is in RUN.
- done  out  1  one-cycle pulse when a run completes.
- sig_valid  out  1  captured signature is available.
- sig_ready  in  1  logger accepts the signature.
- sig_data  out  16  captured acc_value.
- sig_phase  out  4  phase index of sig_data.
- sig_seed  out  8  seed in force when sig_data was captured.
- overrun  out  1  sticky: a capture was lost.

## Operation
- FSM states: IDLE, RUN, DONE.
- Registered state: state, cyc (16-bit in-phase counter), phase (4-bit), the capture buffer, and overrun.

IDLE
- dut_reset=1, cnt_en=0.
- start=1 → RUN with cyc=0 and phase=0.

RUN
- cyc increments every cycle.
- When cyc=PHASE_LEN-1: cyc→0 and phase increments.
- If phase=NUM_PHASES-1 at that point, go to DONE instead.

DONE
- Lasts 1 cycle: done=1, dut_reset=1.
- Then → IDLE.

abort=1 in RUN → IDLE next edge. Captures already buffered are kept.

Outputs decoded from registered state, with no combinational path from inputs except cnt_en:
- dut_reset (in RUN) = 1 when cyc ∈ {0,1,2,3,4,8,17}, else 0.
- cnt_en = (state==RUN) & !dut_reset & !counter_full.
- seed = (phase < SEED_SWITCH_PHASE) ? SEED_A : SEED_B. In IDLE and DONE, phase=0, so seed = SEED_A.
- busy = (state==RUN).

Capture: in RUN, the edge at which cyc==CAPTURE_CYCLE loads sig_data=acc_value, sig_phase=phase and sig_seed=seed, and sets sig_valid.

Handshake:
- sig_valid holds until an edge where sig_valid & sig_ready; sig_data, sig_phase and sig_seed are stable while valid.
- A capture while sig_valid=1 and sig_ready=0 discards the new value, keeps the old value and sets overrun.
- A capture on the same edge as an accept loads the new value; sig_valid stays 1 and no overrun occurs.
- overrun clears only on reset.

## Timing
- Reset values: state=IDLE, cyc=0, phase=0, dut_reset=1, cnt_en=0, seed=SEED_A, busy=0, done=0, sig_valid=0, sig_data=0, sig_phase=0, sig_seed=0, overrun=0.
- A run lasts NUM_PHASES×PHASE_LEN cycles in RUN, plus 1 DONE cycle. With defaults: 960 cycles of RUN, then done.
- Capture latency: sig_valid goes high in the cycle after cyc==CAPTURE_CYCLE.
- Reset mid-run: the block returns to the reset values on the next edge. Reset has priority over abort, and abort has priority over start.

## Test plan
- Defaults: reset, then a 1-cycle start pulse. Required response:
  - dut_reset high for RUN cycles 0–4, 8 and 17 of each phase, low elsewhere.
  - busy high for 960 cycles, then done=1 for exactly 1 cycle.
- sig_ready tied 1 and acc_value driven as a free-running count. Required response: three captures with sig_phase 0/1/2, sig_seed AA/AA/FF, and sig_data equal to acc_value at cyc 310 of each phase.
- counter_full forced 1 for cycles 100–199 of phase 0. Required response: cnt_en=0 for exactly those cycles, and cyc and phase keep advancing.
- sig_ready held 0 for the whole run. Required response: the phase 0 value is retained, overrun=1 from the phase 1 capture onward, and the value is delivered after sig_ready rises.
- abort at phase 1, cyc 50. Required response: the next cycle is IDLE with dut_reset=1, no done pulse, and the phase 0 signature is still valid.
- reset asserted at phase 2, cyc 5. Required response: all outputs take their reset values on the next edge; a new start runs a full 960-cycle sequence.
